sb_crc_engine: RTL and testbench
================================

SB_CRC_ENGINE -- requirements
Module: sb_crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16, CRC register width (an integer multiple of DATA_BITS).
REQ-002 SHALL have parameter POLY, default 16'h8005, generator polynomial with the implicit x^CRC_W term omitted.
REQ-003 SHALL have parameter INIT, default all-ones, CRC register seed value.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per sideband frame; frame length F = DATA_BITS+2.
REQ-005 SHALL have port sb_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port crc_en, input, 1 bit: session enable; low holds the block idle.
REQ-008 SHALL have port mode, input, 1 bit: 0 = generate, 1 = check; sampled only on the IDLE->CALC transition.
REQ-009 SHALL have port crc_active, input, 1 bit: next frame starts the CRC field (emit in generate mode, receive in check mode).
REQ-010 SHALL have port trans_ser, input, 1 bit: serial sideband bit stream, one bit per cycle while crc_en=1.
REQ-011 SHALL have port parity, output, 1 bit: serial framed CRC output.
REQ-012 SHALL have port crc_done, output, 1 bit: one-cycle pulse at the end of the CRC field.
REQ-013 SHALL have port crc_err, output, 1 bit: check-mode mismatch flag.

Function
REQ-014 SHALL keep frame counter cnt in range 0..F-1, incrementing each cycle while crc_en=1 and wrapping F-1->0; cnt=0 is the start bit, cnt=F-1 is the stop bit, others are data bits.
REQ-015 SHALL exclude start and stop bits from every CRC update and shift.
REQ-016 SHALL update on each data bit as follows: fb = reg[CRC_W-1]^trans_ser; reg <= (reg<<1) ^ (fb ? POLY : 0); MSB-first, no reflection, no final XOR.
REQ-017 SHALL implement the FSM states IDLE, CALC, EMIT, RXCRC and DONE.
REQ-018 IDLE SHALL hold reg=INIT and cnt=0, and SHALL go to CALC when crc_en=1, latching mode; the first enabled cycle is cnt=0.
REQ-019 CALC SHALL go to EMIT (mode=0) or RXCRC (mode=1) when crc_active=1 is sampled at cnt=F-1; otherwise CALC SHALL continue frame after frame.
REQ-020 EMIT SHALL drive parity=0 at cnt=0, parity=1 at cnt=F-1, and parity=reg[CRC_W-1] at data bits, shifting reg left with zero fill after each data bit; trans_ser SHALL be ignored in EMIT.
REQ-021 RXCRC SHALL keep applying REQ-016 to the received CRC bits.
REQ-022 EMIT/RXCRC SHALL last exactly CRC_W/DATA_BITS frames, then go to DONE on the cycle after the last stop bit.
REQ-023 crc_done SHALL be high for exactly the first DONE cycle.
REQ-024 In check mode, on entry to DONE, crc_err SHALL be set if reg != 0 and cleared otherwise; in generate mode crc_err SHALL stay 0.
REQ-025 DONE SHALL hold reg, crc_err and parity=0 until crc_en=0.
REQ-026 parity SHALL be 0 in every state other than EMIT, and SHALL be a combinational function of registered state only (no input-to-output path).
REQ-027 crc_en=0 in any state SHALL force IDLE on the next edge: reg=INIT, cnt=0, crc_err=0, and no crc_done pulse.
REQ-028 crc_active outside CALC at cnt=F-1 SHALL be ignored.
REQ-029 crc_active held high across many frames SHALL trigger only one EMIT/RXCRC pass.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force IDLE, reg=INIT, cnt=0, parity=0, crc_done=0 and crc_err=0, including mid-EMIT and mid-RXCRC.
REQ-031 After rst falls, operation SHALL resume only through IDLE->CALC on crc_en=1.

Verification
REQ-032 Default parameters, generate mode, ASCII "123456789" sent as 9 frames (start=0, 8 bits MSB-first, stop=1), then crc_active at the last stop bit -> parity emits frames 0xAE then 0xE7, each with start 0 and stop 1; crc_done pulses once; crc_err=0.
REQ-033 Check mode, "123456789" followed by 0xAE, 0xE7 -> crc_done pulse, crc_err=0, reg=0x0000.
REQ-034 Check mode, same stream with one data bit flipped in byte 3 -> crc_done pulse, crc_err=1.
REQ-035 crc_en dropped mid-EMIT after the first CRC byte -> next cycle IDLE, parity=0, no crc_done pulse, reg=0xFFFF.
REQ-036 rst pulsed asynchronously mid-RXCRC (between clock edges) -> outputs zero immediately; a fresh session then reproduces the REQ-033 result.
REQ-037 CRC_W=8, POLY=8'h07, INIT=8'h00, generate mode, "123456789" -> single emitted frame 0xF4, crc_done pulse.

Source files
------------

// File: rtl/sb_crc_engine.sv
// Serial sideband CRC engine.
// Frames are start bit (0), DATA_BITS data bits MSB-first, then stop bit (1).
// In generate mode the engine appends the CRC as framed bits on parity.
// In check mode it folds the received CRC into the register and flags a
// non-zero residue.
module sb_crc_engine #(
  parameter int               CRC_W     = 16,
  parameter logic [CRC_W-1:0] POLY      = 16'h8005,
  parameter logic [CRC_W-1:0] INIT      = '1,
  parameter int               DATA_BITS = 8
) (
  input  logic sb_clk,
  input  logic rst,
  input  logic crc_en,
  input  logic mode,
  input  logic crc_active,
  input  logic trans_ser,
  output logic parity,
  output logic crc_done,
  output logic crc_err
);

  localparam int F     = DATA_BITS + 2;
  localparam int CNT_W = $clog2(F);
  localparam int NFR   = CRC_W / DATA_BITS;
  localparam int FRM_W = (NFR > 1) ? $clog2(NFR) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NFR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_EMIT  = 3'd2,
    S_RXCRC = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [FRM_W-1:0] r_frm;
  logic [CRC_W-1:0] r_crc;
  logic             r_mode;
  logic             r_done;
  logic             r_err;

  logic             w_data_bit;
  logic             w_last_bit;
  logic             w_frm_last;
  logic             w_parity;

  // One MSB-first CRC step: feedback is the register MSB against the new bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic             b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return (c << 1) ^ (fb ? POLY : '0);
  endfunction

  assign w_data_bit = (r_cnt != '0) && (r_cnt != CNT_LAST);
  assign w_last_bit = (r_cnt == CNT_LAST);
  assign w_frm_last = (r_frm == FRM_LAST);

  // State register.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping crc_en always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!crc_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_CALC;
        S_CALC: begin
          if (w_last_bit && crc_active) begin
            w_state_nxt = r_mode ? S_RXCRC : S_EMIT;
          end
        end
        S_EMIT, S_RXCRC: begin
          if (w_last_bit && w_frm_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: framed CRC bits only while emitting, from registered state.
  always_comb begin
    w_parity = 1'b0;
    if (r_state == S_EMIT) begin
      if (w_last_bit) begin
        w_parity = 1'b1;
      end else if (w_data_bit) begin
        w_parity = r_crc[CRC_W-1];
      end
    end
  end

  // Frame counter, CRC register, CRC-frame counter and latched mode.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_frm  <= '0;
      r_crc  <= INIT;
      r_mode <= 1'b0;
    end else if (!crc_en) begin
      r_cnt <= '0;
      r_frm <= '0;
      r_crc <= INIT;
    end else begin
      r_cnt <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          r_mode <= mode;
          r_crc  <= INIT;
          r_frm  <= '0;
        end
        S_CALC, S_RXCRC: begin
          if (w_data_bit) begin
            r_crc <= crc_step(r_crc, trans_ser);
          end
          if ((r_state == S_RXCRC) && w_last_bit) begin
            r_frm <= r_frm + FRM_W'(1);
          end
        end
        S_EMIT: begin
          if (w_data_bit) begin
            r_crc <= r_crc << 1;
          end
          if (w_last_bit) begin
            r_frm <= r_frm + FRM_W'(1);
          end
        end
        default: begin
          r_crc <= r_crc;
        end
      endcase
    end
  end

  // Done pulse on DONE entry; error flag captures the check residue.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      if (!crc_en || (r_state == S_IDLE)) begin
        r_err <= 1'b0;
      end else if ((r_state == S_RXCRC) && (w_state_nxt == S_DONE)) begin
        r_err <= |r_crc;
      end
    end
  end

  assign parity   = w_parity;
  assign crc_done = r_done;
  assign crc_err  = r_err;

endmodule

// File: tb/tb_sb_crc_engine.sv
// Bench for sb_crc_engine: CRC-16 (0x8005, seed 0xFFFF) and CRC-8 (0x07, seed 0x00).
module tb_sb_crc_engine;

  logic clk;
  logic rst;
  logic crc_en, mode, crc_active, trans_ser;
  logic parity, crc_done, crc_err;
  logic en8, mode8, act8, ts8;
  logic parity8, done8, err8;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done16 = 0;
  int n_done8  = 0;

  typedef struct packed {
    logic        err;
    logic [19:0] frames;
  } exp16_t;

  exp16_t      q16[$];
  logic [9:0]  q8[$];
  exp16_t      e16;
  logic [9:0]  e8;
  logic [19:0] hist16 = '0;
  logic [9:0]  hist8  = '0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  sb_crc_engine dut (
    .sb_clk    (clk),
    .rst       (rst),
    .crc_en    (crc_en),
    .mode      (mode),
    .crc_active(crc_active),
    .trans_ser (trans_ser),
    .parity    (parity),
    .crc_done  (crc_done),
    .crc_err   (crc_err)
  );

  sb_crc_engine #(
    .CRC_W    (8),
    .POLY     (8'h07),
    .INIT     (8'h00),
    .DATA_BITS(8)
  ) dut8 (
    .sb_clk    (clk),
    .rst       (rst),
    .crc_en    (en8),
    .mode      (mode8),
    .crc_active(act8),
    .trans_ser (ts8),
    .parity    (parity8),
    .crc_done  (done8),
    .crc_err   (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor for the 16-bit engine: compares each crc_done against the scoreboard.
  always @(negedge clk) begin
    if (crc_done === 1'b1) begin
      n_done16++;
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        chk("crc_err_at_done16", {31'd0, crc_err}, {31'd0, e16.err});
        chk("emitted_frames16", {12'd0, hist16}, {12'd0, e16.frames});
      end
    end
    hist16 = {hist16[18:0], parity};
  end

  // Monitor for the 8-bit engine.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      n_done8++;
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("crc_err_at_done8", {31'd0, err8}, 32'd0);
        chk("emitted_frames8", {22'd0, hist8}, {22'd0, e8});
      end
    end
    hist8 = {hist8[8:0], parity8};
  end

  task automatic drive(input bit sel, input logic en, input logic ts, input logic act);
    @(negedge clk);
    if (sel) begin
      en8 = en; ts8 = ts; act8 = act;
    end else begin
      crc_en = en; trans_ser = ts; crc_active = act;
    end
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic act);
    drive(sel, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) drive(sel, 1'b1, b[i], 1'b0);
    drive(sel, 1'b1, 1'b1, act);
  endtask

  task automatic send_msg(input bit sel, input bit flip3);
    logic [7:0] b;
    for (int k = 0; k < 9; k++) begin
      b = msg[k];
      if (flip3 && (k == 2)) b = b ^ 8'h04;
      send_frame(sel, b, (k == 8));
    end
  endtask

  task automatic check_idle16(input string tag);
    chk({tag, "_parity"}, {31'd0, parity}, 32'd0);
    chk({tag, "_done"},   {31'd0, crc_done}, 32'd0);
    chk({tag, "_err"},    {31'd0, crc_err}, 32'd0);
    chk({tag, "_reg"},    {16'd0, dut.r_crc}, 32'h0000FFFF);
    chk({tag, "_cnt"},    {28'd0, dut.r_cnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    crc_en = 0; mode = 0; crc_active = 0; trans_ser = 0;
    en8 = 0; mode8 = 0; act8 = 0; ts8 = 0;
    repeat (3) @(negedge clk);
    check_idle16("reset");
    chk("reset_reg8", {24'd0, dut8.r_crc}, 32'd0);
    rst = 1'b0;
    idle(0, 2);

    // Generate mode, "123456789" -> 0xAE, 0xE7 framed on parity.
    mode = 1'b0;
    q16.push_back('{err: 1'b0, frames: {1'b0, 8'hAE, 1'b1, 1'b0, 8'hE7, 1'b1}});
    send_msg(0, 1'b0);
    repeat (20) drive(0, 1'b1, 1'($urandom), 1'($urandom));
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1);
    chk("gen_done_one_cycle", {31'd0, crc_done}, 32'd0);
    chk("gen_done_parity", {31'd0, parity}, 32'd0);
    chk("gen_err_zero", {31'd0, crc_err}, 32'd0);
    idle(0, 2);
    check_idle16("gen_after");

    // Check mode, clean stream -> zero residue.
    mode = 1'b1;
    q16.push_back('{err: 1'b0, frames: 20'd0});
    send_msg(0, 1'b0);
    send_frame(0, 8'hAE, 1'b0);
    send_frame(0, 8'hE7, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    chk("check_residue", {16'd0, dut.r_crc}, 32'd0);
    drive(0, 1'b1, 1'b0, 1'b0);
    chk("check_done_one_cycle", {31'd0, crc_done}, 32'd0);
    chk("check_err_held0", {31'd0, crc_err}, 32'd0);
    idle(0, 2);

    // Check mode, byte 3 corrupted -> error; then async reset clears it.
    mode = 1'b1;
    q16.push_back('{err: 1'b1, frames: 20'd0});
    send_msg(0, 1'b1);
    send_frame(0, 8'hAE, 1'b0);
    send_frame(0, 8'hE7, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    chk("err_held", {31'd0, crc_err}, 32'd1);
    chk("err_done_one_cycle", {31'd0, crc_done}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("async_rst_clears_err", {31'd0, crc_err}, 32'd0);
    crc_en = 1'b0;
    #1 rst = 1'b0;
    idle(0, 2);

    // Generate mode, crc_en dropped after the first CRC byte.
    mode = 1'b0;
    send_msg(0, 1'b0);
    repeat (10) drive(0, 1'b1, 1'($urandom), 1'b0);
    #1 chk("first_crc_byte", {22'd0, hist16[9:0]}, {22'd0, 1'b0, 8'hAE, 1'b1});
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    check_idle16("drop_emit");
    idle(0, 2);

    // Check mode, async reset part-way through the received CRC.
    mode = 1'b1;
    send_msg(0, 1'b0);
    send_frame(0, 8'hAE, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle16("rst_rxcrc");
    crc_en = 1'b0;
    #1 rst = 1'b0;
    idle(0, 3);
    chk("stay_idle_cnt", {28'd0, dut.r_cnt}, 32'd0);

    // Fresh check session after the reset.
    mode = 1'b1;
    q16.push_back('{err: 1'b0, frames: 20'd0});
    send_msg(0, 1'b0);
    send_frame(0, 8'hAE, 1'b0);
    send_frame(0, 8'hE7, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    chk("fresh_residue", {16'd0, dut.r_crc}, 32'd0);
    idle(0, 2);

    // CRC-8 engine, generate mode -> single frame 0xF4.
    mode8 = 1'b0;
    q8.push_back({1'b0, 8'hF4, 1'b1});
    send_msg(1, 1'b0);
    repeat (10) drive(1, 1'b1, 1'($urandom), 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    chk("crc8_done_one_cycle", {31'd0, done8}, 32'd0);
    chk("crc8_parity_done", {31'd0, parity8}, 32'd0);
    idle(1, 3);

    chk("done16_pulses", n_done16, 32'd4);
    chk("done8_pulses", n_done8, 32'd1);
    chk("q16_drained", q16.size(), 32'd0);
    chk("q8_drained", q8.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
